bin_text_buffer: RTL and testbench

BIN_TEXT_BUFFER -- requirements
Module: bin_text_buffer

---
 rtl/bin_text_buffer.sv | 160 ++++++++++++++++
 tb/tb_bin_text_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_text_buffer.sv
// Converts sixteen 16-bit binary words to 5-digit decimal ASCII with a double-dabble engine
// and holds the 80 characters in a registered-read character buffer.
`timescale 1ns/1ps
module bin_text_buffer #(
  parameter int unsigned LEAD_BLANK = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] data_raw,
  input  logic         start,
  input  logic [6:0]   rd_addr,
  output logic [6:0]   rd_data,
  output logic         busy,
  output logic         done
);

  localparam int unsigned NUM_ENTRIES = 80;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned BCD_W       = 20;
  localparam logic [6:0]  CH_SPACE    = 7'h20;
  localparam logic [6:0]  CH_ZERO     = 7'h30;
  localparam logic [6:0]  LAST_ENTRY  = 7'(NUM_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [255:0]       r_shadow;
  logic [BCD_W-1:0]   r_bcd;
  logic [WORD_W-1:0]  r_bin;
  logic [3:0]         r_cnt;
  logic [3:0]         r_word;
  logic [2:0]         r_dig;
  logic               r_nz;
  logic [6:0]         r_buf [NUM_ENTRIES];

  logic [BCD_W-1:0]   w_adj;
  logic [3:0]         w_digit;
  logic               w_blank;
  logic [6:0]         w_char;
  logic [6:0]         w_waddr;
  logic               w_we;
  logic [WORD_W-1:0]  w_word;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    w_digit = r_bcd[3:0];
    case (r_dig)
      3'd0:    w_digit = r_bcd[19:16];
      3'd1:    w_digit = r_bcd[15:12];
      3'd2:    w_digit = r_bcd[11:8];
      3'd3:    w_digit = r_bcd[7:4];
      default: w_digit = r_bcd[3:0];
    endcase
  end

  // Units digit is never blanked so a zero word still shows "0".
  assign w_blank = (LEAD_BLANK != 0) && !r_nz && (w_digit == 4'd0) && (r_dig != 3'd4);
  assign w_char  = w_blank ? CH_SPACE : (CH_ZERO + 7'(w_digit));
  assign w_waddr = (7'(r_word) * 7'd5) + 7'(r_dig);
  assign w_we    = (r_state == S_WRITE);
  assign w_word  = r_shadow[{r_word, 4'b0000} +: WORD_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_bcd    <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_word   <= '0;
      r_dig    <= '0;
      r_nz     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_shadow <= data_raw;
            r_word   <= '0;
            busy     <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_bcd   <= '0;
          r_bin   <= w_word;
          r_cnt   <= '0;
          r_dig   <= '0;
          r_nz    <= 1'b0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_dig <= r_dig + 3'd1;
          if (w_digit != 4'd0) begin
            r_nz <= 1'b1;
          end
          if (r_dig == 3'd4) begin
            if (r_word == 4'd15) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_word  <= r_word + 4'd1;
              r_state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Character store with registered read; a same-cycle write is not visible to the read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_buf[i] <= CH_SPACE;
      end
      rd_data <= CH_SPACE;
    end else begin
      if (w_we) begin
        r_buf[w_waddr] <= w_char;
      end
      rd_data <= (rd_addr < LAST_ENTRY) ? r_buf[rd_addr] : CH_SPACE;
    end
  end

endmodule

// File: tb/tb_bin_text_buffer.sv
// Directed bench for bin_text_buffer: reset state, conversion timing, buffer contents,
// input isolation, abort by reset, zero-padded variant and read/write collision.
`timescale 1ns/1ps
module tb_bin_text_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] data_raw, data_raw0;
  logic         start, start0;
  logic [6:0]   rd_addr, rd_addr0;
  logic [6:0]   rd_data, rd_data0;
  logic         busy, busy0, done, done0;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [6:0] exp80 [80];

  always #5 clk = ~clk;

  bin_text_buffer u_dut (
    .clk(clk), .reset(reset), .data_raw(data_raw), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
  );

  bin_text_buffer #(.LEAD_BLANK(0)) u_dut0 (
    .clk(clk), .reset(reset), .data_raw(data_raw0), .start(start0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .busy(busy0), .done(done0)
  );

  always @(posedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [6:0] e);
    rd_addr = 7'(a);
    tick();
    check($sformatf("%s[%0d]", tag, a), 32'(rd_data), 32'(e));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    start0 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic load_data();
    data_raw = '0;
    for (int i = 3; i < 15; i++) data_raw[i*16 +: 16] = 16'd7;
    data_raw[0*16 +: 16]  = 16'd12345;
    data_raw[1*16 +: 16]  = 16'd0;
    data_raw[2*16 +: 16]  = 16'd100;
    data_raw[15*16 +: 16] = 16'd65535;
  endtask

  task automatic build_exp();
    logic [6:0] w0 [5]  = '{7'h31, 7'h32, 7'h33, 7'h34, 7'h35};
    logic [6:0] w1 [5]  = '{7'h20, 7'h20, 7'h20, 7'h20, 7'h30};
    logic [6:0] w2 [5]  = '{7'h20, 7'h20, 7'h31, 7'h30, 7'h30};
    logic [6:0] w15 [5] = '{7'h36, 7'h35, 7'h35, 7'h33, 7'h35};
    for (int i = 3; i < 15; i++)
      for (int d = 0; d < 5; d++) exp80[i*5+d] = (d == 4) ? 7'h37 : 7'h20;
    for (int d = 0; d < 5; d++) begin
      exp80[d]    = w0[d];
      exp80[5+d]  = w1[d];
      exp80[10+d] = w2[d];
      exp80[75+d] = w15[d];
    end
  endtask

  // Start one conversion and count busy cycles; optionally disturb inputs mid-run.
  task automatic run_conv(input bit perturb, output int bcyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (perturb) data_raw = '1;
    bcyc = 0;
    while (busy && bcyc < 400) begin
      bcyc++;
      check("no_done_while_busy", 32'(done), 32'd0);
      start = perturb && (bcyc == 50);
      tick();
    end
    start = 1'b0;
    check("done_after_busy", 32'(done), 32'd1);
    check("busy_low_in_done", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 80; a++) rd_chk(tag, a, exp80[a]);
  endtask

  initial begin
    int bcyc;
    int dbase;
    int g;
    logic [6:0] e0 [5] = '{7'h30, 7'h30, 7'h30, 7'h34, 7'h32};

    reset = 1'b1;
    start = 1'b0;
    start0 = 1'b0;
    rd_addr = '0;
    rd_addr0 = '0;
    data_raw = '0;
    data_raw0 = '0;
    build_exp();
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h20);
    reset = 1'b0;
    tick();
    for (int a = 0; a < 128; a++) rd_chk("post_reset", a, 7'h20);

    // Read/write collision on word 0: entry d is written at the edge 18+d after start.
    load_data();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    for (int d = 0; d < 5; d++) rd_chk("collide_old", d, 7'h20);
    for (int d = 0; d < 5; d++) rd_chk("late_new", d, exp80[d]);
    g = 0;
    while (!done && g < 500) begin g++; tick(); end
    check("collide_run_done", 32'(done), 32'd1);

    // Main conversion.
    do_reset();
    load_data();
    dbase = done_cnt;
    run_conv(1'b0, bcyc);
    check("busy_cycles", 32'(bcyc), 32'd352);
    check_all("conv");
    check("done_count", 32'(done_cnt - dbase), 32'd1);

    // Data changed after start and start re-pulsed mid-conversion.
    do_reset();
    load_data();
    dbase = done_cnt;
    run_conv(1'b1, bcyc);
    check("busy_cycles_pert", 32'(bcyc), 32'd352);
    check_all("pert");
    check("done_count_pert", 32'(done_cnt - dbase), 32'd1);

    // Reset in the middle of a conversion.
    do_reset();
    load_data();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    check("busy_before_abort", 32'(busy), 32'd1);
    dbase = done_cnt;
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (400) tick();
    check("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    for (int a = 0; a < 80; a++) rd_chk("abort_buf", a, 7'h20);

    // Zero-padded variant.
    data_raw0 = '0;
    data_raw0[15:0] = 16'd42;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    g = 0;
    while (!done0 && g < 500) begin g++; tick(); end
    check("lb0_done", 32'(done0), 32'd1);
    for (int a = 0; a < 10; a++) begin
      rd_addr0 = 7'(a);
      tick();
      check($sformatf("lb0[%0d]", a), 32'(rd_data0), (a < 5) ? 32'(e0[a]) : 32'h30);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
